// File: rtl/lucas_lehmer_engine.sv
// Lucas-Lehmer primality engine for Mersenne numbers 2^p-1 with a runtime exponent.
// Radix-2^R shift-add squarer, fold-based Mersenne reduction, abort and cycle reporting.
module lucas_lehmer_engine #(
    parameter int unsigned PMAX  = 31,
    parameter int unsigned R     = 1,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [EXP_W-1:0] exponent,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic             err,
    output logic [PMAX-1:0]  residue,
    output logic [CYC_W-1:0] cycles
);

    // ceil(pmax / r) by repeated addition, keeping the design divider-free
    function automatic int unsigned calc_ndig(input int unsigned pmax, input int unsigned r);
        int unsigned n;
        n = 0;
        while (n * r < pmax) n++;
        return n;
    endfunction

    localparam int unsigned NDIG   = calc_ndig(PMAX, R);
    localparam int unsigned ACC_W  = 2 * PMAX;
    localparam int unsigned SPAD_W = NDIG * R;
    localparam int unsigned T_W    = PMAX + 1;
    localparam int unsigned K_W    = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_RED,
        S_CHK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [EXP_W-1:0]   p_q, p_d;
    logic [PMAX-1:0]    s_q, s_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               errf_q, errf_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               busy_d, done_d, is_prime_d, err_d;
    logic [PMAX-1:0]    residue_d;
    logic [CYC_W-1:0]   cycles_d;

    logic [SPAD_W-1:0]  s_pad;
    logic [R-1:0]       digit;
    logic [31:0]        shamt;
    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   mask_acc;
    logic [T_W-1:0]     mp, t, u0, u;
    logic [PMAX-1:0]    s_red;
    logic [CYC_W-1:0]   cyc_inc;
    logic               busy_state, bad_exp;

    // One radix-2^R partial product of s*s per MUL cycle
    assign s_pad   = SPAD_W'(s_q);
    assign shamt   = 32'(k_q) * 32'(R);
    assign digit   = R'(s_pad >> shamt);
    assign partial = (ACC_W'(s_q) * ACC_W'(digit)) << shamt;

    // Mersenne fold: 2^p == 1 mod M_p, so add the high half onto the low half twice
    assign mask_acc = (ACC_W'(1) << p_q) - ACC_W'(1);
    assign mp       = (T_W'(1) << p_q) - T_W'(1);
    assign t        = T_W'(PMAX'(acc_q & mask_acc)) + T_W'(PMAX'(acc_q >> p_q));
    assign u0       = (t & mp) + (t >> p_q);
    assign u        = (u0 == mp) ? '0 : u0;
    assign s_red    = (u >= T_W'(2)) ? PMAX'(u - T_W'(2)) : PMAX'(u + mp - T_W'(2));

    assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
    assign busy_state = (state_q == S_MUL) || (state_q == S_RED) || (state_q == S_CHK);
    assign bad_exp    = (exponent < EXP_W'(2)) || (32'(exponent) > PMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            s_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            errf_q   <= 1'b0;
            cyc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_prime <= 1'b0;
            err      <= 1'b0;
            residue  <= '0;
            cycles   <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            s_q      <= s_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            errf_q   <= errf_d;
            cyc_q    <= cyc_d;
            busy     <= busy_d;
            done     <= done_d;
            is_prime <= is_prime_d;
            err      <= err_d;
            residue  <= residue_d;
            cycles   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        s_d        = s_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        errf_d     = errf_q;
        cyc_d      = cyc_q;
        busy_d     = busy;
        done_d     = 1'b0;
        is_prime_d = is_prime;
        err_d      = err;
        residue_d  = residue;
        cycles_d   = cycles;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d    = exponent;
                    acc_d  = '0;
                    k_d    = '0;
                    cyc_d  = '0;
                    busy_d = 1'b1;
                    // Trivial and out-of-range exponents spend a single busy cycle
                    if (bad_exp) begin
                        errf_d  = 1'b1;
                        s_d     = '0;
                        state_d = S_CHK;
                    end else if (exponent == EXP_W'(2)) begin
                        errf_d  = 1'b0;
                        s_d     = '0;
                        state_d = S_CHK;
                    end else begin
                        errf_d  = 1'b0;
                        s_d     = PMAX'(4);
                        cnt_d   = exponent - EXP_W'(2);
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                cyc_d = cyc_inc;
                acc_d = acc_q + partial;
                if (k_q == K_W'(NDIG - 1)) begin
                    k_d     = '0;
                    state_d = S_RED;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_RED: begin
                cyc_d   = cyc_inc;
                s_d     = s_red;
                cnt_d   = cnt_q - EXP_W'(1);
                acc_d   = '0;
                state_d = (cnt_q == EXP_W'(1)) ? S_CHK : S_MUL;
            end
            S_CHK: begin
                cyc_d      = cyc_inc;
                cycles_d   = cyc_inc;
                residue_d  = s_q;
                is_prime_d = (s_q == '0) && !errf_q;
                err_d      = errf_q;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards the running test and leaves the previous results visible
        if (abort && busy_state) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            is_prime_d = is_prime;
            err_d      = err;
            residue_d  = residue;
            cycles_d   = cycles;
        end
    end

endmodule

// File: doc/lucas_lehmer_engine.md
Name: lucas_lehmer_engine

Overview:
Runtime-exponent Lucas-Lehmer primality engine for Mersenne numbers M_p = 2^p - 1, with 3 <= p <= PMAX. It generalises the fixed-exponent tester with three changes:
- a parametrised radix-2^R shift-add squarer;
- division-free Mersenne fold reduction;
- abort, error and residue reporting.
It sits behind the host-side start/done handshake and reports a cycle count for throughput benchmarking.

Parameters:
PMAX, 31, largest supported exponent; datapath width of s and residue.
R, 1, multiplier bits consumed per MUL cycle; NDIG = ceil(PMAX/R).
EXP_W, 8, width of exponent port.
CYC_W, 16, width of cycles counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-high reset.
start  in  1  request; accepted only in IDLE.
abort  in  1  cancel current test; honoured only while busy.
exponent  in  EXP_W  p; sampled only on the accepting edge.
busy  out  1  high from the cycle after acceptance until done.
done  out  1  single-cycle pulse; results are valid on it and held until the next acceptance.
is_prime  out  1  1 when M_p is prime.
err  out  1  1 when p is out of range.
residue  out  PMAX  final s_(p-2) mod M_p, zero-extended.
cycles  out  CYC_W  busy cycles of the last test; saturates at all-ones.

Behaviour:
- Reset (async, any time, including mid-test): state=IDLE. busy, done, is_prime, err, residue and cycles all 0. Internal s, cnt and accumulator are cleared.
- Acceptance: IDLE and start=1 on a clock edge. Latch p. start while busy is ignored, with no queuing.
- Range check at acceptance:
  - p==2: next state DONE; is_prime=1, residue=0.
  - p<2 or p>PMAX: next state DONE; err=1, is_prime=0, residue=0.
  - Otherwise: s=4, cnt=p-2, next state MUL.
- States: IDLE -> MUL -> RED -> (MUL | CHK) -> DONE -> IDLE.
- MUL: exactly NDIG cycles.
  - Each cycle: acc += (s * s[R*k +: R]) << (R*k), for k = 0..NDIG-1.
  - acc is 2*PMAX bits wide. Bits of s at or above p are always 0.
- RED: one cycle.
  - t = acc[p-1:0] + (acc >> p), (p+1) bits.
  - u = t[p-1:0] + t[p].
  - If u == M_p then u = 0.
  - s = (u >= 2) ? u-2 : u + M_p - 2.
  - cnt--. If cnt == 0 go to CHK, else clear acc and return to MUL.
- CHK: one cycle. Set residue=s and is_prime=(s==0). Go to DONE.
- DONE: one cycle. busy=0, done=1. Return to IDLE.
- No / or % operators anywhere; reduction uses masks and shifts with a p-dependent mask only.
- busy is high in MUL, RED and CHK, plus the range-error/p==2 cycle.
- cycles counts the clocks busy was high:
  - (p-2)*(NDIG+1)+1 for a valid p>=3;
  - 1 for p==2 or an error.
- Abort while busy: go to IDLE on the next edge with no done pulse. is_prime, err, residue and cycles keep their previous values. abort in IDLE is ignored.
- start and abort asserted together in IDLE: start wins. While busy, abort wins.
- cycles counter: cleared on acceptance, incremented each busy cycle, saturates at 2^CYC_W-1.

Test Plan:
- Reset check: assert rst for 2 cycles mid-MUL at p=13 -> all outputs 0 immediately (async); a later start at p=13 runs normally.
- p=13, default parameters -> done after 353 busy cycles; is_prime=1, residue=0, err=0, cycles=353.
- p=11 (M=2047=23*89) -> is_prime=0, residue=1736, cycles=289. Repeat with p=17 -> is_prime=1, cycles=481.
- p=31 -> is_prime=1, cycles=929. With R=4 (NDIG=8): p=31 -> is_prime=1, cycles=262.
- Error and trivial cases:
  - p=32 -> err=1, is_prime=0, cycles=1.
  - p=2 -> is_prime=1, err=0, cycles=1.
  - p=0 -> err=1.
- Handshake:
  - start held high for 5 cycles -> only one test runs.
  - abort 50 cycles into p=19 -> busy drops the next cycle, no done; outputs retain the prior test's values; a fresh p=19 then gives is_prime=1, cycles=545.
